pc_fetch_sequencer: RTL and testbench

- Stage-1 fetch controller that owns the architectural fetch PC.
- Drives the PC_Sel select of the stage-1 next-PC mux, which chooses between PC+4 and the stage-2 ALU target.
- Issues one-outstanding instruction-cache requests. Absorbs backend stalls and stage-2 redirects, and squashes wrong-path fetches so decode only sees valid, in-order instructions.

---
 rtl/pc_fetch_sequencer_pkg.sv | 18 +
 rtl/pc_fetch_sequencer_redirect_latch.sv | 29 ++
 rtl/pc_fetch_sequencer.sv | 133 +++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared stage-1 fetch control definitions: PC mux select encodings, FSM states
// and default boot/trap addresses.
package pc_fetch_sequencer_pkg;

    localparam logic PC_SEL_PC_4 = 1'b0;
    localparam logic PC_SEL_ALU  = 1'b1;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_2000;
    localparam logic [31:0] TRAP_PC_DEF  = 32'h0000_0100;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/pc_fetch_sequencer_redirect_latch.sv
// Pending-redirect latch: remembers a redirect that arrived while a fetch was in
// flight, so the returning wrong-path response can be dropped. Last redirect wins.
module pc_redirect_latch (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        set,
    input  logic        clear,
    input  logic [31:0] target_in,
    output logic        stale,
    output logic        redirect_pend,
    output logic [31:0] target
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stale         <= 1'b0;
            redirect_pend <= 1'b0;
            target        <= '0;
        end else if (set) begin
            stale         <= 1'b1;
            redirect_pend <= 1'b1;
            target        <= target_in;
        end else if (clear) begin
            stale         <= 1'b0;
            redirect_pend <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Stage-1 fetch sequencer: owns fetch PC, one-outstanding icache handshake,
// redirect/stall handling. Optional misaligned-redirect trap: PC_SEQ_MISALIGN_TRAP_EN.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] TRAP_PC  = TRAP_PC_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic [31:0] pc_4,
    input  logic [31:0] pc_mux_out,
    output logic        pc_sel,
    output logic        ic_req_valid,
    input  logic        ic_req_ready,
    output logic [31:0] ic_addr,
    input  logic        ic_resp_valid,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    output logic        misalign_trap,
`endif
    output logic        kill
);

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] tgt;
    logic        mis;
    logic        redir;
    logic        stale;
    logic        redirect_pend;
    logic [31:0] lat_target;
    logic        lat_set;
    logic        lat_clear;
    logic        resp_in;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    // Misaligned targets are replaced by the trap vector before anything sees them.
    assign mis = |redirect_target[1:0];
    assign tgt = mis ? TRAP_PC : redirect_target;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) misalign_trap <= 1'b0;
        else          misalign_trap <= redir & mis;
    end

    logic unused_ok;
    assign unused_ok = ^pc_4;
`else
    assign mis = 1'b0;
    assign tgt = redirect_target;

    logic unused_ok;
    assign unused_ok = ^{pc_4, TRAP_PC};
`endif

    assign redir        = redirect & (state != S_BOOT);
    assign resp_in      = (state == S_RESP) & ic_resp_valid;
    assign ic_req_valid = (state == S_REQ);
    assign ic_addr      = fetch_pc;
    assign pc_sel       = (redir & ~mis) | (redirect_pend & resp_in) ? PC_SEL_ALU : PC_SEL_PC_4;

    // Latch only when a request is (or is becoming) outstanding and its response is not here yet.
    assign lat_set   = redir & (((state == S_REQ) & ic_req_ready) | ((state == S_RESP) & ~ic_resp_valid));
    assign lat_clear = resp_in;

    pc_redirect_latch u_latch (
        .clk           (clk),
        .reset_n       (reset_n),
        .set           (lat_set),
        .clear         (lat_clear),
        .target_in     (tgt),
        .stale         (stale),
        .redirect_pend (redirect_pend),
        .target        (lat_target)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_BOOT;
            fetch_pc   <= RESET_PC;
            inst_valid <= 1'b0;
            inst_pc    <= '0;
            kill       <= 1'b0;
        end else begin
            inst_valid <= 1'b0;
            kill       <= 1'b0;
            unique case (state)
                S_BOOT: state <= S_REQ;
                S_REQ: begin
                    if (ic_req_ready)  state    <= S_RESP;
                    else if (redirect) fetch_pc <= tgt;
                end
                S_RESP: begin
                    if (ic_resp_valid) begin
                        state <= S_REQ;
                        if (redirect) begin
                            fetch_pc <= tgt;
                        end else if (stale) begin
                            fetch_pc <= lat_target;
                        end else if (stall) begin
                            state      <= S_HOLD;
                            inst_valid <= 1'b1;
                            inst_pc    <= fetch_pc;
                        end else begin
                            inst_valid <= 1'b1;
                            inst_pc    <= fetch_pc;
                            fetch_pc   <= pc_mux_out;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        kill     <= 1'b1;
                        fetch_pc <= tgt;
                        state    <= S_REQ;
                    end else if (stall) begin
                        inst_valid <= 1'b1;
                    end else begin
                        fetch_pc <= pc_mux_out;
                        state    <= S_REQ;
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer; models the stage-1 adder and next-PC mux.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] pc_4;
    logic [31:0] pc_mux_out;
    logic        pc_sel;
    logic        ic_req_valid;
    logic        ic_req_ready = 1'b0;
    logic [31:0] ic_addr;
    logic        ic_resp_valid = 1'b0;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic        kill;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign pc_4       = ic_addr + 32'd4;
    assign pc_mux_out = pc_sel ? redirect_target : pc_4;

    pc_fetch_sequencer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .pc_4            (pc_4),
        .pc_mux_out      (pc_mux_out),
        .pc_sel          (pc_sel),
        .ic_req_valid    (ic_req_valid),
        .ic_req_ready    (ic_req_ready),
        .ic_addr         (ic_addr),
        .ic_resp_valid   (ic_resp_valid),
        .inst_valid      (inst_valid),
        .inst_pc         (inst_pc),
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        .misalign_trap   (misalign_trap),
`endif
        .kill            (kill)
    );

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (ic_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", ic_req_valid); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid got %b exp 0", inst_valid); end
        checks++; if (kill !== 1'b0) begin errors++; $display("FAIL rst_kill got %b exp 0", kill); end
        checks++; if (pc_sel !== 1'b0) begin errors++; $display("FAIL rst_pc_sel got %b exp 0", pc_sel); end
        checks++; if (ic_addr !== 32'h2000) begin errors++; $display("FAIL rst_addr got %h exp 00002000", ic_addr); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL rst_inst_pc got %h exp 0", inst_pc); end
        reset_n = 1'b1;
        #1;
        checks++; if (ic_req_valid !== 1'b0) begin errors++; $display("FAIL boot_no_req got %b exp 0", ic_req_valid); end
    endtask

    task automatic test_boot();
        ic_req_ready = 1'b1;
        @(negedge clk);
        checks++; if (ic_req_valid !== 1'b1 || ic_addr !== 32'h2000) begin errors++; $display("FAIL boot_first_req got v=%b a=%h exp v=1 a=00002000", ic_req_valid, ic_addr); end
        @(negedge clk);
        checks++; if (ic_req_valid !== 1'b0) begin errors++; $display("FAIL boot_accept got %b exp 0", ic_req_valid); end
        ic_resp_valid = 1'b1;
        @(negedge clk);
        ic_resp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h2000) begin errors++; $display("FAIL boot_inst got v=%b pc=%h exp v=1 pc=00002000", inst_valid, inst_pc); end
        checks++; if (ic_req_valid !== 1'b1 || ic_addr !== 32'h2004) begin errors++; $display("FAIL boot_next got v=%b a=%h exp v=1 a=00002004", ic_req_valid, ic_addr); end
    endtask

    task automatic test_backpressure();
        ic_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (ic_req_valid !== 1'b1 || ic_addr !== 32'h2004 || inst_valid !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got v=%b a=%h iv=%b exp v=1 a=00002004 iv=0", i, ic_req_valid, ic_addr, inst_valid); end
        end
        ic_req_ready = 1'b1;
        @(negedge clk);
        checks++; if (ic_req_valid !== 1'b0) begin errors++; $display("FAIL bp_single_accept got %b exp 0", ic_req_valid); end
        ic_resp_valid = 1'b1;
        @(negedge clk);
        ic_resp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h2004 || ic_addr !== 32'h2008) begin errors++; $display("FAIL bp_inst got v=%b pc=%h a=%h exp 1 00002004 00002008", inst_valid, inst_pc, ic_addr); end
    endtask

    task automatic test_redirect_inflight();
        @(negedge clk);
        redirect = 1'b1; redirect_target = 32'h3000;
        #1;
        checks++; if (pc_sel !== 1'b1) begin errors++; $display("FAIL rif_pc_sel got %b exp 1", pc_sel); end
        @(negedge clk);
        redirect = 1'b0; ic_resp_valid = 1'b1;
        #1;
        checks++; if (pc_sel !== 1'b1) begin errors++; $display("FAIL rif_pc_sel_update got %b exp 1", pc_sel); end
        @(negedge clk);
        ic_resp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rif_squash got %b exp 0", inst_valid); end
        checks++; if (ic_req_valid !== 1'b1 || ic_addr !== 32'h3000) begin errors++; $display("FAIL rif_next got v=%b a=%h exp 1 00003000", ic_req_valid, ic_addr); end
    endtask

    task automatic test_stall_redirect();
        @(negedge clk);
        ic_resp_valid = 1'b1; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ic_resp_valid = 1'b0;
            checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h3000 || ic_req_valid !== 1'b0) begin errors++; $display("FAIL hold%0d got iv=%b pc=%h rv=%b exp 1 00003000 0", i, inst_valid, inst_pc, ic_req_valid); end
        end
        redirect = 1'b1; redirect_target = 32'h4000;
        #1;
        checks++; if (pc_sel !== 1'b1) begin errors++; $display("FAIL hold_pc_sel got %b exp 1", pc_sel); end
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (kill !== 1'b1 || inst_valid !== 1'b0) begin errors++; $display("FAIL hold_kill got k=%b iv=%b exp k=1 iv=0", kill, inst_valid); end
        checks++; if (ic_req_valid !== 1'b1 || ic_addr !== 32'h4000) begin errors++; $display("FAIL hold_next got v=%b a=%h exp 1 00004000", ic_req_valid, ic_addr); end
        @(negedge clk);
        checks++; if (kill !== 1'b0) begin errors++; $display("FAIL kill_pulse got %b exp 0", kill); end
        stall = 1'b0; ic_resp_valid = 1'b1;
        @(negedge clk);
        ic_resp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4000 || ic_addr !== 32'h4004) begin errors++; $display("FAIL post_kill got iv=%b pc=%h a=%h exp 1 00004000 00004004", inst_valid, inst_pc, ic_addr); end
    endtask

    task automatic test_stall_release();
        @(negedge clk);
        ic_resp_valid = 1'b1; stall = 1'b1;
        @(negedge clk);
        ic_resp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4004) begin errors++; $display("FAIL rel_hold got iv=%b pc=%h exp 1 00004004", inst_valid, inst_pc); end
        stall = 1'b0;
        #1;
        checks++; if (pc_sel !== 1'b0) begin errors++; $display("FAIL rel_pc_sel got %b exp 0", pc_sel); end
        @(negedge clk);
        checks++; if (inst_valid !== 1'b0 || ic_req_valid !== 1'b1 || ic_addr !== 32'h4008) begin errors++; $display("FAIL rel_next got iv=%b v=%b a=%h exp 0 1 00004008", inst_valid, ic_req_valid, ic_addr); end
    endtask

    task automatic test_redirect_req();
        ic_req_ready = 1'b0; redirect = 1'b1; redirect_target = 32'h5000;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (ic_req_valid !== 1'b1 || ic_addr !== 32'h5000) begin errors++; $display("FAIL retarget got v=%b a=%h exp 1 00005000", ic_req_valid, ic_addr); end
        ic_req_ready = 1'b1;
        @(negedge clk);
        ic_resp_valid = 1'b1;
        @(negedge clk);
        ic_resp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h5000 || ic_addr !== 32'h5004) begin errors++; $display("FAIL retarget_inst got iv=%b pc=%h a=%h exp 1 00005000 00005004", inst_valid, inst_pc, ic_addr); end
    endtask

    task automatic test_last_wins();
        @(negedge clk);
        redirect = 1'b1; redirect_target = 32'h6000;
        @(negedge clk);
        redirect_target = 32'h7000;
        @(negedge clk);
        redirect = 1'b0; ic_resp_valid = 1'b1;
        @(negedge clk);
        ic_resp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0 || ic_addr !== 32'h7000) begin errors++; $display("FAIL last_wins got iv=%b a=%h exp 0 00007000", inst_valid, ic_addr); end
    endtask

    task automatic test_same_cycle_drop();
        @(negedge clk);
        ic_resp_valid = 1'b1; redirect = 1'b1; redirect_target = 32'h8000;
        @(negedge clk);
        ic_resp_valid = 1'b0; redirect = 1'b0;
        checks++; if (inst_valid !== 1'b0 || ic_req_valid !== 1'b1 || ic_addr !== 32'h8000) begin errors++; $display("FAIL same_cycle got iv=%b v=%b a=%h exp 0 1 00008000", inst_valid, ic_req_valid, ic_addr); end
    endtask

    task automatic test_wrap();
        ic_req_ready = 1'b0; redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0; ic_req_ready = 1'b1;
        @(negedge clk);
        ic_resp_valid = 1'b1;
        @(negedge clk);
        ic_resp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || ic_addr !== 32'h0) begin errors++; $display("FAIL wrap got iv=%b pc=%h a=%h exp 1 fffffffc 00000000", inst_valid, inst_pc, ic_addr); end
    endtask

    task automatic test_misalign();
        logic        exp_sel;
        logic [31:0] exp_addr;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        exp_sel = 1'b0; exp_addr = 32'h0000_0100;
`else
        exp_sel = 1'b1; exp_addr = 32'h0000_3002;
`endif
        ic_req_ready = 1'b0; redirect = 1'b1; redirect_target = 32'h3002;
        #1;
        checks++; if (pc_sel !== exp_sel) begin errors++; $display("FAIL mis_pc_sel got %b exp %b", pc_sel, exp_sel); end
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (ic_addr !== exp_addr) begin errors++; $display("FAIL mis_addr got %h exp %h", ic_addr, exp_addr); end
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        checks++; if (misalign_trap !== 1'b1) begin errors++; $display("FAIL mis_trap got %b exp 1", misalign_trap); end
        @(negedge clk);
        checks++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL mis_trap_pulse got %b exp 0", misalign_trap); end
`endif
    endtask

    task automatic test_async_reset();
        ic_req_ready = 1'b1;
        @(negedge clk);
        checks++; if (ic_req_valid !== 1'b0) begin errors++; $display("FAIL ar_in_resp got %b exp 0", ic_req_valid); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (ic_req_valid !== 1'b0 || inst_valid !== 1'b0 || kill !== 1'b0 || pc_sel !== 1'b0 || ic_addr !== 32'h2000) begin errors++; $display("FAIL ar_immediate got v=%b iv=%b k=%b s=%b a=%h exp 0 0 0 0 00002000", ic_req_valid, inst_valid, kill, pc_sel, ic_addr); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1; ic_resp_valid = 1'b1;
        @(negedge clk);
        ic_resp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0 || ic_req_valid !== 1'b1 || ic_addr !== 32'h2000) begin errors++; $display("FAIL ar_restart got iv=%b v=%b a=%h exp 0 1 00002000", inst_valid, ic_req_valid, ic_addr); end
        @(negedge clk);
        ic_resp_valid = 1'b1;
        @(negedge clk);
        ic_resp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h2000 || ic_addr !== 32'h2004) begin errors++; $display("FAIL ar_inst got iv=%b pc=%h a=%h exp 1 00002000 00002004", inst_valid, inst_pc, ic_addr); end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_backpressure();
        test_redirect_inflight();
        test_stall_redirect();
        test_stall_release();
        test_redirect_req();
        test_last_wins();
        test_same_cycle_drop();
        test_wrap();
        test_misalign();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
